// File: rtl/sdq_pkg.sv
// rtl/sdq_pkg.sv - shared defaults and pointer helper for the sdq queue controller
package sdq_pkg;

    localparam int SDQ_DEPTH = 17;
    localparam int SDQ_WIDTH = 64;
    localparam int SDQ_AW    = 5;

    // Depth is not a power of two, so the wrap has to be explicit.
    function automatic int unsigned ptr_inc_wrap(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1 >= depth) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sdq_ctrl_if.sv
// rtl/sdq_ctrl_if.sv - producer/consumer handshakes and 1R1W memory port bundle
interface sdq_ctrl_if
    import sdq_pkg::*;
#(
    parameter int WIDTH = SDQ_WIDTH,
    parameter int AW    = SDQ_AW
);
    logic             flush;
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_data;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_data;
    logic [AW-1:0]    count;
    logic [AW-1:0]    W0_addr;
    logic             W0_en;
    logic [WIDTH-1:0] W0_data;
    logic [AW-1:0]    R0_addr;
    logic             R0_en;
    logic [WIDTH-1:0] R0_data;

    modport slave (
        input  flush, enq_valid, enq_data, deq_ready, R0_data,
        output enq_ready, deq_valid, deq_data, count,
               W0_addr, W0_en, W0_data, R0_addr, R0_en
    );

    modport master (
        output flush, enq_valid, enq_data, deq_ready, R0_data,
        input  enq_ready, deq_valid, deq_data, count,
               W0_addr, W0_en, W0_data, R0_addr, R0_en
    );
endinterface

// File: rtl/sdq_ptr.sv
// rtl/sdq_ptr.sv - wrapping address pointer with synchronous clear and increment
module sdq_ptr
    import sdq_pkg::*;
#(
    parameter int DEPTH = SDQ_DEPTH,
    parameter int AW    = SDQ_AW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [AW-1:0] o_ptr
);

    logic [AW-1:0] r_ptr;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= AW'(ptr_inc_wrap(32'(r_ptr), 32'(DEPTH)));
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/sdq_ctrl.sv
// rtl/sdq_ctrl.sv - queue controller over an external 1R1W memory with a registered output stage
module sdq_ctrl
    import sdq_pkg::*;
#(
    parameter int DEPTH = SDQ_DEPTH,
    parameter int WIDTH = SDQ_WIDTH,
    parameter int AW    = SDQ_AW
) (
    input  logic      clock,
    input  logic      reset_n,
    sdq_ctrl_if.slave bus
);

    // One extra bit so mem_cnt can hold DEPTH even when DEPTH == 2**AW.
    localparam int CW = AW + 1;

    logic [CW-1:0]    r_mem_cnt;
    logic             r_deq_valid;
    logic [WIDTH-1:0] r_deq_data;
    logic [AW-1:0]    r_count;

    logic [AW-1:0]    w_head;
    logic [AW-1:0]    w_tail;
    logic             w_active;
    logic             w_enq_ready;
    logic             w_enq;
    logic             w_load;
    logic             w_deq;
    logic [CW-1:0]    w_mem_cnt_nxt;
    logic             w_deq_valid_nxt;

    assign w_active    = reset_n && !bus.flush;
    assign w_enq_ready = w_active && (r_mem_cnt < CW'(DEPTH));
    assign w_enq       = w_enq_ready && bus.enq_valid;
    // Uses registered mem_cnt, so a word written this cycle is never read back this cycle.
    assign w_load      = w_active && (r_mem_cnt != '0) && (!r_deq_valid || bus.deq_ready);
    assign w_deq       = r_deq_valid && bus.deq_ready;

    always_comb begin
        w_mem_cnt_nxt = r_mem_cnt;
        case ({w_enq, w_load})
            2'b10:   w_mem_cnt_nxt = r_mem_cnt + CW'(1);
            2'b01:   w_mem_cnt_nxt = r_mem_cnt - CW'(1);
            default: w_mem_cnt_nxt = r_mem_cnt;
        endcase
    end

    always_comb begin
        w_deq_valid_nxt = r_deq_valid;
        if (w_load) begin
            w_deq_valid_nxt = 1'b1;
        end else if (w_deq) begin
            w_deq_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_mem_cnt   <= '0;
            r_deq_valid <= 1'b0;
            r_deq_data  <= '0;
            r_count     <= '0;
        end else if (bus.flush) begin
            r_mem_cnt   <= '0;
            r_deq_valid <= 1'b0;
            r_count     <= '0;
        end else begin
            r_mem_cnt   <= w_mem_cnt_nxt;
            r_deq_valid <= w_deq_valid_nxt;
            r_count     <= AW'(w_mem_cnt_nxt + CW'(w_deq_valid_nxt));
            if (w_load) begin
                r_deq_data <= bus.R0_data;
            end
        end
    end

    sdq_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_head (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clr   (bus.flush),
        .i_inc   (w_load),
        .o_ptr   (w_head)
    );

    sdq_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tail (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clr   (bus.flush),
        .i_inc   (w_enq),
        .o_ptr   (w_tail)
    );

    assign bus.enq_ready = w_enq_ready;
    assign bus.deq_valid = r_deq_valid;
    assign bus.deq_data  = r_deq_data;
    assign bus.count     = r_count;

    assign bus.W0_en     = w_enq;
    assign bus.W0_addr   = w_tail;
    assign bus.W0_data   = bus.enq_data;
    assign bus.R0_en     = w_load;
    assign bus.R0_addr   = w_head;

endmodule

// File: tb/tb_sdq_ctrl.sv
// tb/tb_sdq_ctrl.sv - directed scoreboard bench for sdq_ctrl with a behavioural 17x64 memory
module tb_sdq_ctrl;

    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_bad;
    logic [63:0] sb[$];
    logic [63:0] mem[0:31];

    sdq_ctrl_if #(.WIDTH(64), .AW(5)) bus ();

    sdq_ctrl #(
        .DEPTH (17),
        .WIDTH (64),
        .AW    (5)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.W0_en) mem[bus.W0_addr] <= bus.W0_data;
    end
    assign bus.R0_data = mem[bus.R0_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: push accepted words, pop and compare on every dequeue.
    always @(negedge clock) begin
        if (!reset_n || bus.flush) begin
            sb.delete();
        end else begin
            if (bus.W0_en) check("w0_addr_range", 64'(bus.W0_addr < 5'd17), 64'd1);
            if (bus.R0_en) check("r0_addr_range", 64'(bus.R0_addr < 5'd17), 64'd1);
            if (bus.deq_valid && bus.deq_ready) begin
                if (sb.size() != 0) check("deq_order", bus.deq_data, sb.pop_front());
                else check("deq_unexpected", 64'(bus.deq_valid), 64'd0);
            end
            if (bus.enq_valid && bus.enq_ready) sb.push_back(bus.enq_data);
        end
    end

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.flush     = 1'b0;
        bus.enq_valid = 1'b1;
        bus.enq_data  = 64'hBAD;
        bus.deq_ready = 1'b1;
        @(negedge clock);
        check("rst_enq_ready", 64'(bus.enq_ready), 64'd0);
        check("rst_w0_en", 64'(bus.W0_en), 64'd0);
        check("rst_r0_en", 64'(bus.R0_en), 64'd0);
        nxt();
        reset_n       = 1'b1;
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        bus.deq_ready = 1'b1;
        bus.enq_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (bus.deq_valid === 1'b0 && bus.count === 5'd0) break;
            nxt();
        end
        check($sformatf("%s_count", tag), 64'(bus.count), 64'd0);
        check($sformatf("%s_deq_valid", tag), 64'(bus.deq_valid), 64'd0);
        check($sformatf("%s_sb_empty", tag), 64'(sb.size()), 64'd0);
        nxt();
        bus.deq_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        reset_n       = 1'b0;
        bus.flush     = 1'b0;
        bus.enq_valid = 1'b0;
        bus.enq_data  = '0;
        bus.deq_ready = 1'b0;

        // Reset state and single-word latency
        do_reset();
        bus.enq_valid = 1'b1;
        bus.enq_data  = 64'hA5;
        @(negedge clock);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
        check("rst_deq_data", bus.deq_data, 64'd0);
        check("t1_enq_ready", 64'(bus.enq_ready), 64'd1);
        check("t1_w0_en", 64'(bus.W0_en), 64'd1);
        check("t1_w0_addr", 64'(bus.W0_addr), 64'd0);
        check("t1_w0_data", bus.W0_data, 64'hA5);
        nxt();
        bus.enq_valid = 1'b0;
        @(negedge clock);
        check("t1_c1_r0_en", 64'(bus.R0_en), 64'd1);
        check("t1_c1_deq_valid", 64'(bus.deq_valid), 64'd0);
        nxt();
        @(negedge clock);
        check("t1_c2_deq_valid", 64'(bus.deq_valid), 64'd1);
        check("t1_c2_deq_data", bus.deq_data, 64'hA5);
        check("t1_c2_count", 64'(bus.count), 64'd1);
        nxt();
        drain("t1");

        // Fill to 18, write address wraps, then dequeue while full
        do_reset();
        for (int k = 0; k < 18; k++) begin
            bus.enq_valid = 1'b1;
            bus.enq_data  = 64'(k);
            @(negedge clock);
            check($sformatf("t2_enq_ready_%0d", k), 64'(bus.enq_ready), 64'd1);
            check($sformatf("t2_w0_addr_%0d", k), 64'(bus.W0_addr), 64'(k % 17));
            nxt();
        end
        bus.enq_data  = 64'd100;
        bus.deq_ready = 1'b1;
        @(negedge clock);
        check("t2_full_enq_ready", 64'(bus.enq_ready), 64'd0);
        check("t2_full_w0_en", 64'(bus.W0_en), 64'd0);
        check("t2_full_count", 64'(bus.count), 64'd18);
        check("t2_full_r0_addr", 64'(bus.R0_addr), 64'd1);
        nxt();
        @(negedge clock);
        check("t2_after_enq_ready", 64'(bus.enq_ready), 64'd1);
        check("t2_after_w0_addr", 64'(bus.W0_addr), 64'd1);
        nxt();
        drain("t2");

        // Streaming at one word per cycle
        do_reset();
        bus.deq_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            bus.enq_valid = 1'b1;
            bus.enq_data  = 64'(k);
            @(negedge clock);
            if (k < 2) begin
                check($sformatf("t3_fill_count_%0d", k), 64'(bus.count), 64'(k));
                check($sformatf("t3_fill_deq_valid_%0d", k), 64'(bus.deq_valid), 64'd0);
            end else begin
                check($sformatf("t3_count_%0d", k), 64'(bus.count), 64'd2);
                check($sformatf("t3_deq_valid_%0d", k), 64'(bus.deq_valid), 64'd1);
                check($sformatf("t3_deq_data_%0d", k), bus.deq_data, 64'(k - 2));
            end
            nxt();
        end
        drain("t3");

        // Flush discards queued words and the same-cycle enqueue
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.enq_valid = 1'b1;
            bus.enq_data  = 64'h50 + 64'(k);
            nxt();
        end
        bus.flush     = 1'b1;
        bus.enq_data  = 64'hFF;
        bus.deq_ready = 1'b1;
        @(negedge clock);
        check("t4_flush_enq_ready", 64'(bus.enq_ready), 64'd0);
        check("t4_flush_w0_en", 64'(bus.W0_en), 64'd0);
        check("t4_flush_r0_en", 64'(bus.R0_en), 64'd0);
        nxt();
        bus.flush     = 1'b0;
        bus.deq_ready = 1'b0;
        bus.enq_data  = 64'h3C;
        @(negedge clock);
        check("t4_post_count", 64'(bus.count), 64'd0);
        check("t4_post_deq_valid", 64'(bus.deq_valid), 64'd0);
        check("t4_post_w0_addr", 64'(bus.W0_addr), 64'd0);
        nxt();
        bus.enq_valid = 1'b0;
        nxt();
        @(negedge clock);
        check("t4_3c_deq_valid", 64'(bus.deq_valid), 64'd1);
        check("t4_3c_deq_data", bus.deq_data, 64'h3C);
        nxt();
        drain("t4");

        // Mid-operation reset abandons everything
        do_reset();
        for (int k = 0; k < 7; k++) begin
            bus.enq_valid = 1'b1;
            bus.enq_data  = 64'h70 + 64'(k);
            nxt();
        end
        bus.enq_valid = 1'b0;
        nxt();
        @(negedge clock);
        check("t5_pre_count", 64'(bus.count), 64'd7);
        nxt();
        do_reset();
        @(negedge clock);
        check("t5_rst_count", 64'(bus.count), 64'd0);
        check("t5_rst_deq_valid", 64'(bus.deq_valid), 64'd0);
        check("t5_rst_deq_data", bus.deq_data, 64'd0);
        nxt();
        bus.deq_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check($sformatf("t5_idle_deq_valid_%0d", k), 64'(bus.deq_valid), 64'd0);
            nxt();
        end
        bus.enq_valid = 1'b1;
        bus.enq_data  = 64'h3D;
        nxt();
        drain("t5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
